// File: rtl/memory_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// GENERAL_DEFS
// Shared pipeline definitions: datapath widths, the writeback data-source
// selector, and the MEM-stage access-size and FSM-state enums. It also holds
// small helpers that turn an access size into an aligned address and
// byte-lane enables.
// -----------------------------------------------------------------------------
package GENERAL_DEFS;

  localparam int WORD       = 32;
  localparam int ADDR_WIDTH = 5;

  // Selects which value the writeback stage writes to the register file.
  typedef enum logic [1:0] {
    SRC_ALU       = 2'b00,
    SRC_MEM       = 2'b01,
    SRC_PC_PLUS_4 = 2'b10,
    SRC_IMM       = 2'b11
  } reg_file_data_source;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD_SZ = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_stage_state_t;

  // The raw size encoding 2'b11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD_SZ;
    endcase
  endfunction

  // Clear the address bits that fall below the access granule.
  function automatic logic [WORD-1:0] align_addr(input logic [WORD-1:0] addr,
                                                 input mem_size_t       size);
    logic [WORD-1:0] aligned;
    aligned = addr;
    case (size)
      HALF:    aligned[0]   = 1'b0;
      WORD_SZ: aligned[1:0] = 2'b00;
      default: aligned      = addr;
    endcase
    return aligned;
  endfunction

  function automatic logic [3:0] lane_enables(input mem_size_t  size,
                                              input logic [1:0] addr_lo);
    case (size)
      BYTE:    return 4'b0001 << addr_lo;
      HALF:    return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load formatter. It picks the addressed byte or halfword lane
// out of the memory read word and then zero- or sign-extends it. Word loads
// pass through unchanged.
//   size      : access size (BYTE / HALF / WORD_SZ)
//   is_signed : sign-extend sub-word results
//   addr_lo   : address bits [1:0] (lane select)
//   rdata     : raw data memory read word
//   data      : extended load result
// -----------------------------------------------------------------------------
module load_extend
  import GENERAL_DEFS::*;
(
  input  mem_size_t        size,
  input  logic             is_signed,
  input  logic [1:0]       addr_lo,
  input  logic [WORD-1:0]  rdata,
  output logic [WORD-1:0]  data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first); otherwise synthesis infers a latch to hold it.
    byte_lane = rdata[8*addr_lo +: 8];
    half_lane = rdata[16*addr_lo[1] +: 16];
    data      = rdata;
    case (size)
      BYTE:    data = {{(WORD-8){is_signed & byte_lane[7]}}, byte_lane};
      HALF:    data = {{(WORD-16){is_signed & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// Pipeline MEM stage. Loads and stores go to the data memory over a req/ready
// handshake, and the upstream register is held through stall_o while an access
// is outstanding. If the memory does not answer within MAX_WAIT request
// cycles, the access is aborted with a one-cycle fault. All writeback-bound
// fields are registered onto the *_o outputs.
//
// Build option: MEM_ALIGN_CHECK_EN
//   defined   -> a misaligned half/word access raises a fault and issues no
//                request.
//   undefined -> the low address bits are cleared to force alignment.
//
// Ports
//   clk_i, reset_i            : clock, asynchronous active-high reset
//   is_valid_i .. reg_2_data_i: instruction from the execute/memory register
//   dmem_*_o / dmem_*_i       : data memory request / response
//   stall_o                   : combinational hold for the upstream register
//   *_o (writeback)           : registered fields for the writeback stage
//   fault_o                   : one-cycle fault, aligned with is_valid_o
// -----------------------------------------------------------------------------
module memory_access_stage
  import GENERAL_DEFS::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      is_valid_i,
  input  logic                      mem_read_en_i,
  input  logic                      mem_write_en_i,
  input  logic [1:0]                mem_size_i,
  input  logic                      mem_signed_i,
  input  logic                      reg_file_write_en_i,
  input  reg_file_data_source       reg_file_data_source_i,
  input  logic [ADDR_WIDTH-1:0]     reg_dest_addr_i,
  input  logic                      branch_from_wb_i,
  input  logic [WORD-1:0]           alu_result_i,
  input  logic [WORD-1:0]           reg_2_data_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [WORD-1:0]           dmem_addr_o,
  output logic [WORD-1:0]           dmem_wdata_o,
  output logic [3:0]                dmem_be_o,
  input  logic                      dmem_ready_i,
  input  logic [WORD-1:0]           dmem_rdata_i,
  output logic                      stall_o,
  output logic                      is_valid_o,
  output logic                      reg_file_write_en_o,
  output logic                      branch_from_wb_o,
  output reg_file_data_source       reg_file_data_source_o,
  output logic [ADDR_WIDTH-1:0]     reg_dest_addr_o,
  output logic [WORD-1:0]           alu_result_o,
  output logic [WORD-1:0]           mem_data_o,
  output logic                      fault_o
);

  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;

  mem_stage_state_t     state;
  logic [CNT_W-1:0]     wait_cnt;

  // Access captured in IDLE and held stable for the whole REQ phase.
  mem_size_t            lat_size;
  logic                 lat_signed;
  logic                 lat_we;
  logic [WORD-1:0]      lat_alu;
  logic [WORD-1:0]      lat_wdata;
  logic                 lat_rfwe;
  reg_file_data_source  lat_src;
  logic [ADDR_WIDTH-1:0] lat_dest;
  logic                 lat_branch;

  mem_size_t            size_in;
  logic                 mem_op;
  logic                 misaligned;
  logic                 align_fault;
  logic                 access_start;
  logic                 timeout;
  logic [WORD-1:0]      load_data;

  assign size_in = decode_size(mem_size_i);
  assign mem_op  = is_valid_i & (mem_read_en_i | mem_write_en_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((size_in == HALF)    &  alu_result_i[0]) |
                      ((size_in == WORD_SZ) & (|alu_result_i[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  assign align_fault  = mem_op & misaligned;
  assign access_start = (state == IDLE) & mem_op & ~misaligned;
  assign timeout      = (state == REQ) & (wait_cnt == CNT_W'(MAX_WAIT));

  // Reset gates the combinational outputs too, so an outstanding request
  // and the stall vanish the moment reset asserts.
  assign dmem_req_o = ~reset_i & (state == REQ) & ~timeout;
  assign stall_o    = ~reset_i & (access_start | (dmem_req_o & ~dmem_ready_i));

  // Request payload comes only from captured state, never from the live
  // inputs, so it stays stable while the request is pending.
  assign dmem_we_o   = lat_we;
  assign dmem_addr_o = align_addr(lat_alu, lat_size);
  assign dmem_be_o   = lane_enables(lat_size, dmem_addr_o[1:0]);

  always_comb begin
    dmem_wdata_o = lat_wdata;
    case (lat_size)
      BYTE:    dmem_wdata_o = {4{lat_wdata[7:0]}};
      HALF:    dmem_wdata_o = {2{lat_wdata[15:0]}};
      default: dmem_wdata_o = lat_wdata;
    endcase
  end

  load_extend u_load_extend (
    .size      (lat_size),
    .is_signed (lat_signed),
    .addr_lo   (dmem_addr_o[1:0]),
    .rdata     (dmem_rdata_i),
    .data      (load_data)
  );

  // NOTE: clocked state uses non-blocking (<=) assignments so that every
  // flop samples the pre-edge values and the simulation matches the hardware.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state                  <= IDLE;
      wait_cnt               <= '0;
      lat_size               <= BYTE;
      lat_signed             <= 1'b0;
      lat_we                 <= 1'b0;
      lat_alu                <= '0;
      lat_wdata              <= '0;
      lat_rfwe               <= 1'b0;
      lat_src                <= SRC_ALU;
      lat_dest               <= '0;
      lat_branch             <= 1'b0;
      is_valid_o             <= 1'b0;
      reg_file_write_en_o    <= 1'b0;
      branch_from_wb_o       <= 1'b0;
      reg_file_data_source_o <= SRC_ALU;
      reg_dest_addr_o        <= '0;
      alu_result_o           <= '0;
      mem_data_o             <= '0;
      fault_o                <= 1'b0;
    end else if (state == IDLE) begin
      if (access_start) begin
        state               <= REQ;
        wait_cnt            <= '0;
        lat_size            <= size_in;
        lat_signed          <= mem_signed_i;
        lat_we              <= mem_write_en_i;
        lat_alu             <= alu_result_i;
        lat_wdata           <= reg_2_data_i;
        lat_rfwe            <= reg_file_write_en_i;
        lat_src             <= reg_file_data_source_i;
        lat_dest            <= reg_dest_addr_i;
        lat_branch          <= branch_from_wb_i;
        // Bubble toward writeback while the access is in flight.
        is_valid_o          <= 1'b0;
        reg_file_write_en_o <= 1'b0;
        fault_o             <= 1'b0;
      end else begin
        is_valid_o             <= is_valid_i;
        reg_file_write_en_o    <= reg_file_write_en_i & ~align_fault;
        branch_from_wb_o       <= branch_from_wb_i;
        reg_file_data_source_o <= reg_file_data_source_i;
        reg_dest_addr_o        <= reg_dest_addr_i;
        alu_result_o           <= alu_result_i;
        mem_data_o             <= '0;
        fault_o                <= align_fault;
      end
    end else begin
      // Timeout wins over a late ready: the request is already withdrawn.
      if (timeout || dmem_ready_i) begin
        state                  <= IDLE;
        is_valid_o             <= 1'b1;
        fault_o                <= timeout;
        reg_file_write_en_o    <= lat_rfwe & ~timeout;
        branch_from_wb_o       <= lat_branch;
        reg_file_data_source_o <= lat_src;
        reg_dest_addr_o        <= lat_dest;
        alu_result_o           <= lat_alu;
        mem_data_o             <= (timeout | lat_we) ? '0 : load_data;
      end else begin
        wait_cnt   <= wait_cnt + 1'b1;
        is_valid_o <= 1'b0;
        fault_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
// Self-checking bench for memory_access_stage: a table of directed vectors,
// hand-written reset sequences, and randomized operations checked against a
// byte-level reference model.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;
  import GENERAL_DEFS::*;

  localparam int unsigned MAX_WAIT = 15;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic                  is_valid_i, mem_read_en_i, mem_write_en_i, mem_signed_i;
  logic [1:0]            mem_size_i;
  logic                  reg_file_write_en_i, branch_from_wb_i;
  reg_file_data_source   reg_file_data_source_i;
  logic [ADDR_WIDTH-1:0] reg_dest_addr_i;
  logic [WORD-1:0]       alu_result_i, reg_2_data_i;
  logic                  dmem_req_o, dmem_we_o;
  logic [WORD-1:0]       dmem_addr_o, dmem_wdata_o;
  logic [3:0]            dmem_be_o;
  logic                  dmem_ready_i;
  logic [WORD-1:0]       dmem_rdata_i;
  logic                  stall_o, is_valid_o, reg_file_write_en_o, branch_from_wb_o;
  reg_file_data_source   reg_file_data_source_o;
  logic [ADDR_WIDTH-1:0] reg_dest_addr_o;
  logic [WORD-1:0]       alu_result_o, mem_data_o;
  logic                  fault_o;

  memory_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .is_valid_i(is_valid_i), .mem_read_en_i(mem_read_en_i),
    .mem_write_en_i(mem_write_en_i), .mem_size_i(mem_size_i),
    .mem_signed_i(mem_signed_i), .reg_file_write_en_i(reg_file_write_en_i),
    .reg_file_data_source_i(reg_file_data_source_i),
    .reg_dest_addr_i(reg_dest_addr_i), .branch_from_wb_i(branch_from_wb_i),
    .alu_result_i(alu_result_i), .reg_2_data_i(reg_2_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .is_valid_o(is_valid_o),
    .reg_file_write_en_o(reg_file_write_en_o), .branch_from_wb_o(branch_from_wb_o),
    .reg_file_data_source_o(reg_file_data_source_o),
    .reg_dest_addr_o(reg_dest_addr_o), .alu_result_o(alu_result_o),
    .mem_data_o(mem_data_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic        valid, rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        rfwe;
    logic [1:0]  src;
    logic [4:0]  dest;
    logic        br;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_mem_data;
    logic        exp_fault;
  } vec_t;

  function automatic vec_t mk(input logic valid, rd, wr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, wdata,
                              rdata, input int waits, input logic exp_req,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, exp_mem_data,
                              input logic exp_fault);
    vec_t v;
    v.valid = valid; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.rfwe = 1'b1; v.src = 2'b01; v.dest = 5'd7; v.br = 1'b0;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_mem_data = exp_mem_data; v.exp_fault = exp_fault;
    return v;
  endfunction

  // Reference model: derives the expected memory traffic and writeback result
  // from byte counts and offsets.
  function automatic vec_t model(input vec_t v);
    int nbytes, off;
    bit mem, mis, tmo;
    longint unsigned raw;
    longint val;
    nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    mem = v.valid && (v.rd || v.wr);
    mis = ALIGN_EN && ((v.addr % nbytes) != 0);
    v.exp_req  = mem && !mis;
    v.exp_addr = v.addr - (v.addr % nbytes);
    off = int'(v.exp_addr % 4);
    v.exp_be = 4'(((1 << nbytes) - 1) << off);
    for (int b = 0; b < 4; b++) v.exp_wdata[8*b +: 8] = v.wdata[8*(b % nbytes) +: 8];
    tmo = v.exp_req && (v.waits >= int'(MAX_WAIT));
    v.exp_fault = (mem && mis) || tmo;
    raw = {32'h0, v.rdata} >> (8 * off);
    raw = raw % (64'd1 << (8 * nbytes));
    val = longint'(raw);
    if (v.sgn && nbytes < 4 && raw >= (64'd1 << (8 * nbytes - 1)))
      val = val - longint'(64'd1 << (8 * nbytes));
    v.exp_mem_data = (v.exp_req && !v.wr && !tmo) ? val[31:0] : 32'h0;
    return v;
  endfunction

  task automatic idle_inputs();
    is_valid_i = 1'b0; mem_read_en_i = 1'b0; mem_write_en_i = 1'b0;
    dmem_ready_i = 1'b0; dmem_rdata_i = '0;
  endtask

  task automatic apply(input vec_t v);
    is_valid_i = v.valid; mem_read_en_i = v.rd; mem_write_en_i = v.wr;
    mem_size_i = v.size; mem_signed_i = v.sgn; alu_result_i = v.addr;
    reg_2_data_i = v.wdata; reg_file_write_en_i = v.rfwe;
    reg_file_data_source_i = reg_file_data_source'(v.src);
    reg_dest_addr_i = v.dest; branch_from_wb_i = v.br; dmem_ready_i = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the
  // result has been registered, with the next slot's inputs still to be set.
  task automatic run_vec(input string tag, input vec_t v);
    logic exp_valid;
    bit   rdy;
    apply(v);
    if (!v.exp_req) begin
      #1;
      check({tag, ".stall_pass"}, stall_o, 1'b0);
      check({tag, ".req_pass"}, dmem_req_o, 1'b0);
      exp_valid = v.valid | v.exp_fault;
    end else begin
      #1;
      check({tag, ".stall_idle"}, stall_o, 1'b1);
      check({tag, ".req_idle"}, dmem_req_o, 1'b0);
      @(posedge clk_i); #1;
      check({tag, ".bubble"}, is_valid_o, 1'b0);
      for (int c = 0; c <= int'(MAX_WAIT); c++) begin
        if (c == int'(MAX_WAIT)) begin
          #1;
          check({tag, ".req_timeout"}, dmem_req_o, 1'b0);
          check({tag, ".stall_timeout"}, stall_o, 1'b0);
          break;
        end
        rdy = (c >= v.waits);
        dmem_ready_i = rdy;
        dmem_rdata_i = rdy ? v.rdata : $urandom;
        #1;
        check({tag, ".req"}, dmem_req_o, 1'b1);
        check({tag, ".stall_req"}, stall_o, !rdy);
        check({tag, ".we"}, dmem_we_o, v.wr);
        check({tag, ".addr"}, dmem_addr_o, v.exp_addr);
        check({tag, ".be"}, dmem_be_o, v.exp_be);
        if (v.wr) check({tag, ".wdata"}, dmem_wdata_o, v.exp_wdata);
        if (rdy) break;
        @(posedge clk_i); #1;
      end
      exp_valid = 1'b1;
    end
    @(posedge clk_i); #1;
    idle_inputs();
    check({tag, ".is_valid"}, is_valid_o, exp_valid);
    check({tag, ".fault"}, fault_o, v.exp_fault);
    check({tag, ".rfwe"}, reg_file_write_en_o, v.exp_fault ? 1'b0 : v.rfwe);
    check({tag, ".alu_result"}, alu_result_o, v.addr);
    check({tag, ".mem_data"}, mem_data_o, v.exp_mem_data);
    check({tag, ".dest"}, reg_dest_addr_o, v.dest);
    check({tag, ".src"}, reg_file_data_source_o, v.src);
    check({tag, ".branch"}, branch_from_wb_o, v.br);
  endtask

  vec_t vecs[14];

  initial begin
    // valid rd wr size sgn addr wdata rdata waits | req addr be wdata mem_data fault
    vecs[0]  = mk(1,0,0,2'd2,0,32'h0000_1234,32'h0,32'h0,0,        0,32'h0,4'h0,32'h0,32'h0,0);
    vecs[1]  = mk(1,1,0,2'd2,0,32'h0000_0100,32'h0,32'hDEAD_BEEF,1,1,32'h100,4'hF,32'h0,32'hDEAD_BEEF,0);
    vecs[2]  = mk(1,1,0,2'd0,1,32'h0000_0103,32'h0,32'h80FF_FFFF,0,1,32'h103,4'h8,32'h0,32'hFFFF_FF80,0);
    vecs[3]  = mk(1,1,0,2'd0,0,32'h0000_0103,32'h0,32'h80FF_FFFF,0,1,32'h103,4'h8,32'h0,32'h0000_0080,0);
    vecs[4]  = mk(1,0,1,2'd1,0,32'h0000_0202,32'h1234_ABCD,32'h0,2,1,32'h202,4'hC,32'hABCD_ABCD,32'h0,0);
`ifdef MEM_ALIGN_CHECK_EN
    vecs[5]  = mk(1,1,0,2'd2,0,32'h0000_0101,32'h0,32'h1122_3344,0,0,32'h0,4'h0,32'h0,32'h0,1);
    vecs[13] = mk(1,1,0,2'd1,0,32'h0000_0203,32'h0,32'h1234_5678,0,0,32'h0,4'h0,32'h0,32'h0,1);
`else
    vecs[5]  = mk(1,1,0,2'd2,0,32'h0000_0101,32'h0,32'h1122_3344,0,1,32'h100,4'hF,32'h0,32'h1122_3344,0);
    vecs[13] = mk(1,1,0,2'd1,0,32'h0000_0203,32'h0,32'h1234_5678,0,1,32'h202,4'hC,32'h0,32'h0000_1234,0);
`endif
    vecs[6]  = mk(1,0,1,2'd0,0,32'h0000_0001,32'hFFFF_FF5A,32'h0,0,1,32'h001,4'h2,32'h5A5A_5A5A,32'h0,0);
    vecs[7]  = mk(1,1,0,2'd1,1,32'h0000_0002,32'h0,32'h8001_7FFF,0,1,32'h002,4'hC,32'h0,32'hFFFF_8001,0);
    vecs[8]  = mk(1,1,0,2'd1,1,32'h0000_0000,32'h0,32'h8001_7FFF,3,1,32'h000,4'h3,32'h0,32'h0000_7FFF,0);
    vecs[9]  = mk(1,0,1,2'd3,0,32'h0000_0040,32'hCAFE_F00D,32'h0,0,1,32'h040,4'hF,32'hCAFE_F00D,32'h0,0);
    vecs[10] = mk(1,1,1,2'd2,0,32'h0000_0044,32'h0BAD_F00D,32'hFFFF_FFFF,1,1,32'h044,4'hF,32'h0BAD_F00D,32'h0,0);
    vecs[11] = mk(1,1,0,2'd2,0,32'h0000_0080,32'h0,32'h5555_5555,99,1,32'h080,4'hF,32'h0,32'h0,1);
    vecs[12] = mk(0,1,0,2'd2,0,32'h0000_0300,32'h0,32'h0,0,       0,32'h0,4'h0,32'h0,32'h0,0);
    vecs[0].src = 2'b00; vecs[4].br = 1'b1; vecs[9].dest = 5'd31; vecs[12].rfwe = 1'b0;

    // Reset: drive a memory op during reset; nothing may leak out.
    reset_i = 1'b1;
    apply(vecs[1]);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset.is_valid", is_valid_o, 1'b0);
    check("reset.fault", fault_o, 1'b0);
    check("reset.req", dmem_req_o, 1'b0);
    check("reset.stall", stall_o, 1'b0);
    check("reset.mem_data", mem_data_o, 32'h0);
    check("reset.alu_result", alu_result_o, 32'h0);
    idle_inputs();
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted in the middle of a pending request.
    apply(vecs[11]);
    @(posedge clk_i); #1;
    repeat (3) @(posedge clk_i);
    #1;
    check("midreset.req_before", dmem_req_o, 1'b1);
    reset_i = 1'b1;
    #1;
    check("midreset.req", dmem_req_o, 1'b0);
    check("midreset.stall", stall_o, 1'b0);
    check("midreset.is_valid", is_valid_o, 1'b0);
    idle_inputs();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("midreset.req_after", dmem_req_o, 1'b0);
    check("midreset.valid_after", is_valid_o, 1'b0);
    run_vec("recover", vecs[1]);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.valid = ($urandom_range(0, 7) != 0);
      r.rd    = 1'($urandom_range(0, 1));
      r.wr    = 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 3));
      r.sgn   = 1'($urandom_range(0, 1));
      r.addr  = $urandom;
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.waits = ($urandom_range(0, 9) == 0) ? int'(MAX_WAIT) + 5 : int'($urandom_range(0, 3));
      r.rfwe  = 1'($urandom_range(0, 1));
      r.src   = 2'($urandom_range(0, 3));
      r.dest  = 5'($urandom_range(0, 31));
      r.br    = 1'($urandom_range(0, 1));
      run_vec($sformatf("rand%0d", i), model(r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage, sitting between the execute/memory pipeline register and the writeback stage. It issues loads and stores to the data memory over a req/ready handshake and stalls the upstream pipeline while an access is outstanding. Sub-word accesses use byte-lane enables and load sign/zero extension. It registers all writeback-bound fields into its own memory/writeback outputs.

## Interface
- `MAX_WAIT`, default 15: number of REQ cycles without `dmem_ready_i` before the access is aborted with a fault.
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `is_valid_i` in 1: input instruction valid.
- `mem_read_en_i`, `mem_write_en_i` in 1 each: load / store request.
- `mem_size_i` in 2: access size. 00 byte, 01 halfword, 10 word, 11 treated as word.
- `mem_signed_i` in 1: sign-extend sub-word loads.
- `reg_file_write_en_i` in 1, `reg_file_data_source_i` in `reg_file_data_source`, `reg_dest_addr_i` in `ADDR_WIDTH`, `branch_from_wb_i` in 1: writeback controls, passed through.
- `alu_result_i` in `WORD`: effective address, or the result for non-memory ops.
- `reg_2_data_i` in `WORD`: store data.
- `dmem_req_o` out 1, `dmem_we_o` out 1, `dmem_addr_o` out `WORD`, `dmem_wdata_o` out `WORD`, `dmem_be_o` out 4: data memory request.
- `dmem_ready_i` in 1, `dmem_rdata_i` in `WORD`: data memory response.
- `stall_o` out 1: combinational. Upstream holds its register while this is high.
- `is_valid_o`, `reg_file_write_en_o`, `branch_from_wb_o` out 1: registered writeback fields.
- `reg_file_data_source_o` out `reg_file_data_source`, `reg_dest_addr_o` out `ADDR_WIDTH`: registered writeback fields.
- `alu_result_o` out `WORD`, `mem_data_o` out `WORD`: registered writeback fields.
- `fault_o` out 1: registered, one cycle, aligned with `is_valid_o`.

## Operation
- States: IDLE, REQ.
- A memory op is `is_valid_i & (mem_read_en_i | mem_write_en_i)`. If both enables are set, the access is a write.
- **IDLE, non-memory op:**
  - Register all fields to the outputs at the next edge.
  - `mem_data_o` = 0, `stall_o` = 0.
- **IDLE, memory op:**
  - `stall_o` = 1 this cycle.
  - Latch the address, size, signedness, write data and writeback fields.
  - Next state REQ; `is_valid_o` = 0 next cycle (bubble).
- **REQ:**
  - `dmem_req_o` = 1 and the request outputs are held stable.
  - `stall_o` = `!dmem_ready_i`.
  - On `dmem_ready_i` = 1: next edge loads the latched fields onto the outputs with `is_valid_o` = 1; a load's extended data goes to `mem_data_o`; next state IDLE. The held upstream instruction is consumed at that edge.
- **Timeout:**
  - Wait counter clears on REQ entry and increments on each REQ cycle without ready.
  - When it reaches `MAX_WAIT`: `dmem_req_o` drops, `stall_o` = 0, and next cycle `is_valid_o` = 1, `fault_o` = 1, `reg_file_write_en_o` = 0. State returns to IDLE.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`, write data is the low byte replicated ×4.
  - half: `addr[1]` ? 1100 : 0011, write data is the low half replicated ×2.
  - word: 1111.
- **Load extend:**
  - byte: `rdata[8*addr[1:0] +: 8]`.
  - half: `rdata[16*addr[1] +: 16]`.
  - Sub-word results are zero- or sign-extended per `mem_signed_i`; word loads pass through.
- **Reset (any time, including mid-REQ):** state IDLE; all outputs 0; counter 0; an outstanding request is dropped.

## Timing
- Non-memory op: 1-cycle latency, no stall.
- Memory op with zero-wait memory: 2 cycles (IDLE stall cycle, then REQ completes).
- Each wait cycle adds 1.
- Memory must sample `dmem_req_o`, `dmem_addr_o` etc. only while `dmem_req_o` = 1. Completion occurs on the edge where req and ready are both high.
- `stall_o` is a function of the current state and inputs only; it has no path from `dmem_rdata_i`.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned halfword (`addr[0]`) or word (`addr[1:0]` ≠ 0) access issues no request and does not stall.
  - Next cycle: `is_valid_o` = 1, `fault_o` = 1, `reg_file_write_en_o` = 0.
- Undefined:
  - No alignment fault.
  - Address low bits are forced to alignment: half clears bit 0, word clears [1:0].
  - `fault_o` asserts only on timeout.

## Structure
- Shared package (`GENERAL_DEFS`): `WORD`, `ADDR_WIDTH`, `reg_file_data_source`, plus the new `mem_size_t` enum (BYTE, HALF, WORD_SZ) and the `mem_stage_state_t` enum (IDLE, REQ).
- One sub-module, `load_extend`: combinational lane select plus sign/zero extension, taking size, signed, `addr[1:0]` and rdata.

## Test plan
- ALU op, `alu_result_i` = 0x1234 → next cycle `alu_result_o` = 0x1234, `is_valid_o` = 1, `stall_o` never high.
- Word load from 0x100, ready one cycle after req, `rdata` = 0xDEADBEEF → stall for 2 cycles, then `mem_data_o` = 0xDEADBEEF.
- Signed byte load from 0x103, `rdata` = 0x80FFFFFF → `mem_data_o` = 0xFFFFFF80. The unsigned variant gives 0x00000080.
- Halfword store of 0xABCD to 0x202 → `dmem_be_o` = 1100, `dmem_wdata_o` = 0xABCDABCD, `dmem_we_o` = 1.
- Ready held low with `MAX_WAIT` = 15 → `dmem_req_o` drops after 15 REQ cycles, `fault_o` pulses, `reg_file_write_en_o` = 0. Repeat with `reset_i` asserted mid-REQ → `dmem_req_o` and `stall_o` go 0 immediately.
- With `MEM_ALIGN_CHECK_EN`, word load from 0x101 → no `dmem_req_o`, `fault_o` = 1 next cycle. Without the macro → `dmem_addr_o` = 0x100.
